regfile_writeback: RTL and testbench
====================================

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 Parameter BITS_DATA, default 32, SHALL set the data width of every data port and buffer entry.
REQ-002 Parameter BITS_ADDR, default 3, SHALL set the register-address width.
REQ-003 Parameter DEPTH, default 4, power of two, SHALL set the number of write-back buffer entries.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset.
REQ-005 Port list:
 clk  in  1  clock; all state updates on posedge.
 rst_n  in  1  synchronous reset, active low.
 wb_valid  in  1  write-back request present.
 wb_ready  out  1  buffer can accept a request.
 wb_addr  in  BITS_ADDR  destination register.
 wb_data  in  BITS_DATA  value to write.
 drain_en  in  1  permits issue of the buffer head to the register file.
 rf_write_en  out  1  register-file write enable.
 rf_addr  out  BITS_ADDR  register-file write address.
 rf_data  out  BITS_DATA  register-file write data.
 rd_addr1  in  BITS_ADDR  operand-1 lookup address.
 rd_addr2  in  BITS_ADDR  operand-2 lookup address.
 fwd_hit1  out  1  a pending write targets rd_addr1.
 fwd_data1  out  BITS_DATA  youngest pending data for rd_addr1.
 fwd_hit2  out  1  a pending write targets rd_addr2.
 fwd_data2  out  BITS_DATA  youngest pending data for rd_addr2.
 count  out  BITS_ADDR+1  number of occupied entries (0..DEPTH).

Function
REQ-006 The buffer SHALL be an in-order FIFO of {addr, data} entries with registered head/tail pointers and count.
REQ-007 wb_ready SHALL equal (count != DEPTH), derived from registered count only.
REQ-008 A push SHALL occur on a posedge where wb_valid && wb_ready; the entry becomes visible the next cycle.
REQ-009 rf_write_en SHALL equal (count != 0) && drain_en, and rf_addr/rf_data SHALL equal the head entry, driven from registers.
REQ-010 The outputs in REQ-009 SHALL hold stable from posedge to the next posedge, so the register file's negedge write captures them.
REQ-011 A pop SHALL occur on every posedge where rf_write_en is 1; the register file always accepts.
REQ-012 Simultaneous push and pop SHALL leave count unchanged and move both pointers.
REQ-013 When full, a simultaneous pop SHALL NOT make wb_ready high in the same cycle; the request waits one cycle.
REQ-014 Pointers SHALL wrap modulo DEPTH.
REQ-015 count SHALL never exceed DEPTH or go below 0.
REQ-016 fwd_hitN SHALL be 1 when any occupied entry's addr equals rd_addrN; this is combinational on rd_addrN.
REQ-017 fwd_dataN SHALL be the data of the youngest matching occupied entry; it SHALL be 0 when fwd_hitN is 0.
REQ-018 An entry issued this cycle (rf_write_en=1) SHALL still count as pending for forwarding until the posedge that pops it.
REQ-019 wb_data SHALL NOT be forwarded in its own push cycle (no input-to-output path).

Reset
REQ-020 While rst_n=0 at a posedge, count, head and tail SHALL clear to 0 and all entries SHALL be discarded.
REQ-021 After reset: wb_ready=1, rf_write_en=0, rf_addr=0, rf_data=0, fwd_hit1/2=0, fwd_data1/2=0, count=0.
REQ-022 Reset asserted mid-drain SHALL suppress rf_write_en from the next cycle, and no discarded entry SHALL be issued later.
REQ-023 A push in the reset cycle SHALL be ignored.

Structure
REQ-024 BITS_DATA and BITS_ADDR defaults SHALL live in the shared CPU constants package, reused by the register file.
REQ-025 The FIFO storage and pointers SHALL be one sub-module, wb_fifo, with a read-all-entries port for the forwarding match.

Verification
REQ-026 Reset, then push (addr 3, 0xDEADBEEF) with drain_en=1: next cycle rf_write_en=1, rf_addr=3, rf_data=0xDEADBEEF; the following cycle count=0.
REQ-027 drain_en=0, push 4 entries: count=4, wb_ready=0; a 5th wb_valid is not accepted; set drain_en=1 and observe 4 issues in push order.
REQ-028 drain_en=0, push (5, 0x11) then (5, 0x22), rd_addr1=5, rd_addr2=2: fwd_hit1=1, fwd_data1=0x22, fwd_hit2=0, fwd_data2=0.
REQ-029 Full buffer, drain_en=1, wb_valid held: one pop, then accept the next cycle; count sequence 4,3,4.
REQ-030 Three entries pending, drain_en=1, rst_n=0 for one cycle: rf_write_en=0 afterward, count=0, and no further writes.
REQ-031 Run 1000 random push/drain cycles checked against a reference queue model: issue order, count, and forwarding all match.

Source files
------------

// File: rtl/regfile_writeback_pkg.sv
// Shared CPU constants: register-file word and address widths, plus
// write-back buffer sizing helpers used by the buffer and the register file.
package regfile_writeback_pkg;

  localparam int CPU_BITS_DATA    = 32;
  localparam int CPU_BITS_ADDR    = 3;
  localparam int WB_DEPTH_DEFAULT = 4;

  // Pointer width for a buffer of the given depth (at least one bit).
  function automatic int ptr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// In-order FIFO of {addr, data} write-back entries. Exposes every storage
// slot plus the head pointer and count so the parent can search for
// pending writes in age order.
module wb_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int BITS_DATA = CPU_BITS_DATA,
  parameter int BITS_ADDR = CPU_BITS_ADDR,
  parameter int DEPTH     = WB_DEPTH_DEFAULT,
  localparam int PTR_W    = ptr_bits(DEPTH),
  localparam int CNT_W    = BITS_ADDR + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [BITS_ADDR-1:0] push_addr,
  input  logic [BITS_DATA-1:0] push_data,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output logic [PTR_W-1:0]     head,
  output logic [CNT_W-1:0]     count,
  output logic [BITS_ADDR-1:0] ent_addr [DEPTH],
  output logic [BITS_DATA-1:0] ent_data [DEPTH]
);

  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [BITS_ADDR-1:0] mem_addr_q [DEPTH];
  logic [BITS_ADDR-1:0] mem_addr_d [DEPTH];
  logic [BITS_DATA-1:0] mem_data_q [DEPTH];
  logic [BITS_DATA-1:0] mem_data_d [DEPTH];
  logic                 push_ok;
  logic                 pop_ok;

  // Advance a pointer, wrapping explicitly so non-full-range depths also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy update; push and pop together keep count steady.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_ok) head_d = ptr_inc(head_q);
    if (push_ok) tail_d = ptr_inc(tail_q);
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage update: a push writes the slot under the tail pointer.
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (push_ok) begin
      mem_addr_d[tail_q] = push_addr;
      mem_data_d[tail_q] = push_data;
    end
  end

  // Control registers; reset empties the buffer, discarding any entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: slots are only observed while counted as occupied.
  always_ff @(posedge clk) begin
    mem_addr_q <= mem_addr_d;
    mem_data_q <= mem_data_d;
  end

  assign head     = head_q;
  assign count    = count_q;
  assign ent_addr = mem_addr_q;
  assign ent_data = mem_data_q;

endmodule

// File: rtl/regfile_writeback.sv
// Write-back buffer in front of the register file: queues results, drains
// the oldest one per cycle when allowed, and forwards the youngest pending
// value for two operand lookups.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int BITS_DATA = CPU_BITS_DATA,
  parameter int BITS_ADDR = CPU_BITS_ADDR,
  parameter int DEPTH     = WB_DEPTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [BITS_ADDR-1:0] wb_addr,
  input  logic [BITS_DATA-1:0] wb_data,
  input  logic                 drain_en,
  output logic                 rf_write_en,
  output logic [BITS_ADDR-1:0] rf_addr,
  output logic [BITS_DATA-1:0] rf_data,
  input  logic [BITS_ADDR-1:0] rd_addr1,
  input  logic [BITS_ADDR-1:0] rd_addr2,
  output logic                 fwd_hit1,
  output logic [BITS_DATA-1:0] fwd_data1,
  output logic                 fwd_hit2,
  output logic [BITS_DATA-1:0] fwd_data2,
  output logic [BITS_ADDR:0]   count
);

  localparam int PTR_W = ptr_bits(DEPTH);
  localparam int CNT_W = BITS_ADDR + 1;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic [PTR_W-1:0]     head;
  logic [BITS_ADDR-1:0] ent_addr [DEPTH];
  logic [BITS_DATA-1:0] ent_data [DEPTH];
  logic [PTR_W-1:0]     fwd_idx;

  // Ready and issue come only from registered occupancy, so a pop while full
  // cannot open the input in the same cycle.
  assign wb_ready    = !fifo_full;
  assign push        = wb_valid && wb_ready;
  assign rf_write_en = !fifo_empty && drain_en;
  assign pop         = rf_write_en;
  assign rf_addr     = fifo_empty ? '0 : ent_addr[head];
  assign rf_data     = fifo_empty ? '0 : ent_data[head];

  wb_fifo #(
    .BITS_DATA (BITS_DATA),
    .BITS_ADDR (BITS_ADDR),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_addr (wb_addr),
    .push_data (wb_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head),
    .count     (count),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data)
  );

  // Walk occupied slots oldest to youngest so the last match is the youngest;
  // the entry being issued this cycle is still occupied and still forwards.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    fwd_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = PTR_W'((int'(head) + i) % DEPTH);
      if (CNT_W'(i) < count) begin
        if (ent_addr[fwd_idx] == rd_addr1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = ent_data[fwd_idx];
        end
        if (ent_addr[fwd_idx] == rd_addr2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = ent_data[fwd_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: a reference queue holds the
// pending writes; entries are queued when a push is accepted and compared
// against the register-file port when the DUT issues them.
module tb_regfile_writeback;

  localparam int BD    = 32;
  localparam int BA    = 3;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wb_valid = 1'b0;
  logic          wb_ready;
  logic [BA-1:0] wb_addr = '0;
  logic [BD-1:0] wb_data = '0;
  logic          drain_en = 1'b0;
  logic          rf_write_en;
  logic [BA-1:0] rf_addr;
  logic [BD-1:0] rf_data;
  logic [BA-1:0] rd_addr1 = '0;
  logic [BA-1:0] rd_addr2 = '0;
  logic          fwd_hit1;
  logic [BD-1:0] fwd_data1;
  logic          fwd_hit2;
  logic [BD-1:0] fwd_data2;
  logic [BA:0]   count;

  typedef struct {
    logic [BA-1:0] addr;
    logic [BD-1:0] data;
  } entry_t;

  entry_t sb_queue[$];
  int     checks = 0;
  int     failures = 0;
  logic   model_valid = 1'b0;
  logic   exp_push = 1'b0;
  logic   exp_pop = 1'b0;

  always #5 clk = ~clk;

  regfile_writeback #(
    .BITS_DATA (BD),
    .BITS_ADDR (BA),
    .DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .drain_en    (drain_en),
    .rf_write_en (rf_write_en),
    .rf_addr     (rf_addr),
    .rf_data     (rf_data),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .fwd_hit1    (fwd_hit1),
    .fwd_data1   (fwd_data1),
    .fwd_hit2    (fwd_hit2),
    .fwd_data2   (fwd_data2),
    .count       (count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Youngest pending value for an address, from the reference queue.
  task automatic modelFwd(input logic [BA-1:0] a, output logic hit, output logic [BD-1:0] d);
    hit = 1'b0;
    d   = '0;
    foreach (sb_queue[k]) begin
      if (sb_queue[k].addr == a) begin
        hit = 1'b1;
        d   = sb_queue[k].data;
      end
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then compare all outputs.
  task automatic applyStimulus(input logic rst, input logic valid, input logic [BA-1:0] addr,
                               input logic [BD-1:0] data, input logic drain,
                               input logic [BA-1:0] r1, input logic [BA-1:0] r2);
    logic          exp_we;
    logic          h1, h2;
    logic [BD-1:0] d1, d2;
    @(negedge clk);
    rst_n    = rst;
    wb_valid = valid;
    wb_addr  = addr;
    wb_data  = data;
    drain_en = drain;
    rd_addr1 = r1;
    rd_addr2 = r2;
    #1;
    exp_we   = (sb_queue.size() != 0) && drain;
    exp_push = rst && valid && (sb_queue.size() < DEPTH);
    exp_pop  = rst && exp_we;
    if (model_valid) begin
      modelFwd(r1, h1, d1);
      modelFwd(r2, h2, d2);
      checkOutput("count", 32'(count), 32'(sb_queue.size()));
      checkOutput("wb_ready", 32'(wb_ready), 32'(sb_queue.size() < DEPTH));
      checkOutput("rf_write_en", 32'(rf_write_en), 32'(exp_we));
      checkOutput("rf_addr", 32'(rf_addr), (sb_queue.size() != 0) ? 32'(sb_queue[0].addr) : 32'd0);
      checkOutput("rf_data", rf_data, (sb_queue.size() != 0) ? sb_queue[0].data : 32'd0);
      checkOutput("fwd_hit1", 32'(fwd_hit1), 32'(h1));
      checkOutput("fwd_data1", fwd_data1, d1);
      checkOutput("fwd_hit2", 32'(fwd_hit2), 32'(h2));
      checkOutput("fwd_data2", fwd_data2, d2);
    end
  endtask

  // Rising edge: apply the accepted pop/push to the reference queue.
  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      sb_queue.delete();
      model_valid = 1'b1;
    end else begin
      if (exp_pop) void'(sb_queue.pop_front());
      if (exp_push) sb_queue.push_back('{addr: wb_addr, data: wb_data});
    end
  endtask

  task automatic cycle(input logic rst, input logic valid, input logic [BA-1:0] addr,
                       input logic [BD-1:0] data, input logic drain,
                       input logic [BA-1:0] r1, input logic [BA-1:0] r2);
    applyStimulus(rst, valid, addr, data, drain, r1, r2);
    advance();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset with a push request present; the push must be ignored.
    cycle(1'b0, 1'b1, 3'd1, 32'h55, 1'b1, 3'd0, 3'd0);
    applyStimulus(1'b0, 1'b1, 3'd2, 32'h66, 1'b1, 3'd2, 3'd1);
    checkOutput("rst_ready", 32'(wb_ready), 32'd1);
    checkOutput("rst_we", 32'(rf_write_en), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    advance();
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 3'd1, 3'd2);
    checkOutput("rst_push_ignored", 32'(count), 32'd0);
    advance();

    // Single push with drain enabled issues the next cycle.
    cycle(1'b1, 1'b1, 3'd3, 32'hDEADBEEF, 1'b1, 3'd3, 3'd0);
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 3'd3, 3'd0);
    checkOutput("issue_we", 32'(rf_write_en), 32'd1);
    checkOutput("issue_addr", 32'(rf_addr), 32'd3);
    checkOutput("issue_data", rf_data, 32'hDEADBEEF);
    checkOutput("issue_fwd_hit", 32'(fwd_hit1), 32'd1);
    advance();
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 3'd0, 3'd0);
    checkOutput("issue_count0", 32'(count), 32'd0);
    advance();

    // Fill to full with drain off, try a fifth push, then drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, BA'(i + 1), 32'(32'hA0 + i), 1'b0, 3'd0, 3'd0);
    applyStimulus(1'b1, 1'b1, 3'd7, 32'hBAD, 1'b0, 3'd7, 3'd0);
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_ready", 32'(wb_ready), 32'd0);
    advance();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 3'd7, 3'd0);
      checkOutput("drain_order_addr", 32'(rf_addr), 32'(i + 1));
      checkOutput("drain_order_data", rf_data, 32'(32'hA0 + i));
      advance();
    end
    cycle(1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 3'd7, 3'd0);

    // Two writes to the same register: the younger one forwards.
    cycle(1'b1, 1'b1, 3'd5, 32'h11, 1'b0, 3'd5, 3'd2);
    cycle(1'b1, 1'b1, 3'd5, 32'h22, 1'b0, 3'd5, 3'd2);
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 3'd5, 3'd2);
    checkOutput("fwd_young_hit1", 32'(fwd_hit1), 32'd1);
    checkOutput("fwd_young_data1", fwd_data1, 32'h22);
    checkOutput("fwd_miss_hit2", 32'(fwd_hit2), 32'd0);
    checkOutput("fwd_miss_data2", fwd_data2, 32'd0);
    advance();

    // Full buffer with a held request: one pop, then acceptance a cycle later.
    cycle(1'b1, 1'b1, 3'd6, 32'h33, 1'b0, 3'd0, 3'd0);
    cycle(1'b1, 1'b1, 3'd2, 32'h44, 1'b0, 3'd0, 3'd0);
    applyStimulus(1'b1, 1'b1, 3'd4, 32'h55, 1'b1, 3'd4, 3'd0);
    checkOutput("held_count_a", 32'(count), 32'd4);
    checkOutput("held_ready_a", 32'(wb_ready), 32'd0);
    advance();
    applyStimulus(1'b1, 1'b1, 3'd4, 32'h55, 1'b0, 3'd4, 3'd0);
    checkOutput("held_count_b", 32'(count), 32'd3);
    checkOutput("held_ready_b", 32'(wb_ready), 32'd1);
    advance();
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 3'd4, 3'd0);
    checkOutput("held_count_c", 32'(count), 32'd4);
    checkOutput("held_fwd_data", fwd_data1, 32'h55);
    advance();

    // Reset in the middle of draining three entries.
    cycle(1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 3'd0, 3'd0);
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd6, 3'd2);
    checkOutput("mid_rst_we", 32'(rf_write_en), 32'd1);
    checkOutput("mid_rst_count", 32'(count), 32'd3);
    advance();
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 3'd6, 3'd2);
    checkOutput("post_rst_we", 32'(rf_write_en), 32'd0);
    checkOutput("post_rst_count", 32'(count), 32'd0);
    checkOutput("post_rst_fwd", 32'(fwd_hit1), 32'd0);
    advance();
    repeat (3) cycle(1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 3'd6, 3'd4);

    // Random traffic against the reference queue.
    for (int n = 0; n < 1000; n++) begin
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 2) != 0,
            BA'($urandom_range(0, 7)), $urandom, $urandom_range(0, 4) < 2,
            BA'($urandom_range(0, 7)), BA'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
